// File: rtl/demux_rr_dispatcher_if.sv
// Handshake and bus bundle between the round-robin dispatcher, its producer and N consumers.
// The DUT side uses the slave modport; the environment drives through master.
interface demux_rr_dispatcher_if #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 8
);
  localparam int unsigned SW = $clog2(N);

  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic [N-1:0]  out_valid;
  logic [W-1:0]  out_data;
  logic [N-1:0]  out_ready;
  logic [SW-1:0] sel;
  logic [15:0]   stall_cnt;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, sel, stall_cnt
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, sel, stall_cnt
  );
endinterface

// File: rtl/demux_rr_dispatcher.sv
// Single-entry round-robin dispatcher feeding N demux channels from one valid/ready stream.
// Define DEMUX_SKIP_EN to let a stalled target be skipped in favour of the next ready channel.
module demux_rr_dispatcher #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 8
) (
  input logic                   clk,
  input logic                   rst,
  demux_rr_dispatcher_if.slave  bus
);
  localparam int unsigned SW = $clog2(N);
  localparam int          NI = int'(N);

  typedef enum logic {StIdle, StHold} state_e;

  state_e        r_state;
  logic [SW-1:0] r_sel;
  logic [W-1:0]  r_data;
  logic [15:0]   r_stall;

  logic          w_in_xfer;
  logic          w_out_xfer;
  logic          w_in_ready;
  logic [SW-1:0] w_sel_inc;

  assign w_in_ready = !rst && (r_state == StIdle || bus.out_ready[r_sel]);
  assign w_in_xfer  = bus.in_valid && w_in_ready;
  assign w_out_xfer = (r_state == StHold) && bus.out_ready[r_sel];
  assign w_sel_inc  = (r_sel == SW'(N - 1)) ? '0 : r_sel + 1'b1;

`ifdef DEMUX_SKIP_EN
  logic          w_skip_hit;
  logic [SW-1:0] w_skip_sel;
  int            w_best;
  int            w_dist;

  // Nearest ready channel strictly after r_sel in round-robin order.
  always_comb begin
    w_skip_hit = 1'b0;
    w_skip_sel = r_sel;
    w_best     = NI;
    w_dist     = 0;
    for (int j = 0; j < NI; j++) begin
      w_dist = (j + NI - int'(r_sel)) % NI;
      if (bus.out_ready[j] && w_dist != 0 && w_dist < w_best) begin
        w_best     = w_dist;
        w_skip_hit = 1'b1;
        w_skip_sel = SW'(j);
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_sel   <= '0;
      r_data  <= '0;
      r_stall <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_in_xfer) begin
            r_data  <= bus.in_data;
            r_state <= StHold;
          end
        end
        StHold: begin
          if (w_out_xfer) begin
            r_sel <= w_sel_inc;
            if (w_in_xfer) begin
              r_data <= bus.in_data;
            end else begin
              r_state <= StIdle;
            end
          end else begin
            if (r_stall != 16'hFFFF) begin
              r_stall <= r_stall + 16'd1;
            end
`ifdef DEMUX_SKIP_EN
            if (w_skip_hit) begin
              r_sel <= w_skip_sel;
            end
`endif
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == StHold) ? ({{(N-1){1'b0}}, 1'b1} << r_sel) : '0;
  assign bus.out_data  = r_data;
  assign bus.sel       = r_sel;
  assign bus.stall_cnt = r_stall;
endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Directed scoreboard bench for demux_rr_dispatcher: N=2 instance for most steps, N=3 for wrap.
module tb_demux_rr_dispatcher;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  demux_rr_dispatcher_if #(.N(2), .W(8)) b2 ();
  demux_rr_dispatcher_if #(.N(3), .W(8)) b3 ();

  demux_rr_dispatcher #(.N(2), .W(8)) u_dut2 (.clk(clk), .rst(rst), .bus(b2));
  demux_rr_dispatcher #(.N(3), .W(8)) u_dut3 (.clk(clk), .rst(rst), .bus(b3));

  typedef struct {
    int         ch;
    logic [7:0] data;
  } exp_t;

  exp_t q2[$];
  exp_t q3[$];
  int   m2 = 0;
  int   m3 = 0;
  int   pops3 = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon2();
    exp_t e;
    if ((b2.out_valid & b2.out_ready) != 2'b00) begin
      if (q2.size() == 0) begin
        check("sb2_underflow", 32'd1, 32'd0);
      end else begin
        e = q2.pop_front();
        check("ch2", 32'(b2.out_valid), 32'd1 << e.ch);
        check("data2", 32'(b2.out_data), 32'(e.data));
      end
    end
    if (b2.in_valid && b2.in_ready) begin
      q2.push_back('{ch: m2, data: b2.in_data});
      m2 = (m2 + 1) % 2;
    end
  endtask

  task automatic mon3();
    exp_t e;
    if ((b3.out_valid & b3.out_ready) != 3'b000) begin
      if (q3.size() == 0) begin
        check("sb3_underflow", 32'd1, 32'd0);
      end else begin
        e = q3.pop_front();
        pops3++;
        check("ch3", 32'(b3.out_valid), 32'd1 << e.ch);
        check("data3", 32'(b3.out_data), 32'(e.data));
      end
    end
    if (b3.in_valid && b3.in_ready) begin
      q3.push_back('{ch: m3, data: b3.in_data});
      m3 = (m3 + 1) % 3;
    end
  endtask

  // Drive the N=2 inputs for one cycle and score what the DUT shows before the next edge.
  task automatic cyc(input logic v, input logic [7:0] d, input logic [1:0] rdy);
    @(negedge clk);
    b2.in_valid  = v;
    b2.in_data   = d;
    b2.out_ready = rdy;
    #1;
    mon2();
  endtask

  task automatic cyc3(input logic v, input logic [7:0] d, input logic [2:0] rdy);
    @(negedge clk);
    b3.in_valid  = v;
    b3.in_data   = d;
    b3.out_ready = rdy;
    #1;
    mon3();
  endtask

  initial begin
    b2.in_valid = 1'b0; b2.in_data = '0; b2.out_ready = '0;
    b3.in_valid = 1'b0; b3.in_data = '0; b3.out_ready = '0;

    // Reset values
    #12;
    check("rst_in_ready", 32'(b2.in_ready), 32'd0);
    check("rst_out_valid", 32'(b2.out_valid), 32'd0);
    check("rst_sel", 32'(b2.sel), 32'd0);
    check("rst_stall", 32'(b2.stall_cnt), 32'd0);
    check("rst_out_data", 32'(b2.out_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Streaming at full throughput
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b1, 8'(i), 2'b11);
      check("stream_in_ready", 32'(b2.in_ready), 32'd1);
    end
    cyc(1'b0, 8'h00, 2'b11);
    cyc(1'b0, 8'h00, 2'b11);
    check("stream_drain", 32'(q2.size()), 32'd0);
    check("stream_sel", 32'(b2.sel), 32'd0);

    // Backpressure on channel 0
    cyc(1'b1, 8'h3C, 2'b00);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 8'h00, 2'b00);
      check("bp_in_ready", 32'(b2.in_ready), 32'd0);
      check("bp_out_valid", 32'(b2.out_valid), 32'd1);
    end
    cyc(1'b0, 8'h00, 2'b01);
    check("bp_stall", 32'(b2.stall_cnt), 32'd5);
    cyc(1'b0, 8'h00, 2'b00);
    check("bp_idle_valid", 32'(b2.out_valid), 32'd0);
    check("bp_idle_sel", 32'(b2.sel), 32'd1);

    // Bring sel back to 0, then stall channel 0 while channel 1 is ready
    cyc(1'b1, 8'h22, 2'b10);
    cyc(1'b0, 8'h00, 2'b10);
    cyc(1'b1, 8'h11, 2'b10);
    check("skip_accept", 32'(b2.in_ready), 32'd1);
    cyc(1'b0, 8'h00, 2'b10);
    check("skip_sel0", 32'(b2.sel), 32'd0);
    check("skip_valid0", 32'(b2.out_valid), 32'd1);
`ifdef DEMUX_SKIP_EN
    if (q2.size() != 0) q2[0].ch = 1;
    m2 = 0;
    cyc(1'b0, 8'h00, 2'b10);
    check("skip_sel1", 32'(b2.sel), 32'd1);
    cyc(1'b1, 8'h33, 2'b11);
    cyc(1'b0, 8'h00, 2'b11);
    check("skip_stall", 32'(b2.stall_cnt), 32'd6);
`else
    cyc(1'b0, 8'h00, 2'b10);
    check("noskip_sel", 32'(b2.sel), 32'd0);
    cyc(1'b0, 8'h00, 2'b10);
    check("noskip_valid", 32'(b2.out_valid), 32'd1);
    cyc(1'b0, 8'h00, 2'b01);
    cyc(1'b1, 8'h33, 2'b11);
    cyc(1'b0, 8'h00, 2'b11);
    check("noskip_stall", 32'(b2.stall_cnt), 32'd8);
`endif
    check("skip_drain", 32'(q2.size()), 32'd0);

    // Asynchronous reset while holding a word
    cyc(1'b1, 8'hA5, 2'b00);
    cyc(1'b0, 8'h00, 2'b00);
    check("mid_hold_data", 32'(b2.out_data), 32'hA5);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(b2.out_valid), 32'd0);
    check("mid_rst_sel", 32'(b2.sel), 32'd0);
    check("mid_rst_stall", 32'(b2.stall_cnt), 32'd0);
    check("mid_rst_in_ready", 32'(b2.in_ready), 32'd0);
    q2.delete();
    m2 = 0;
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 8'h00, 2'b11);
    check("word_lost", 32'(b2.out_valid), 32'd0);

    // Wrap-around on the N=3 instance
    for (int i = 0; i < 6; i++) begin
      cyc3(1'b1, 8'(8'h10 + i), 3'b111);
    end
    cyc3(1'b0, 8'h00, 3'b111);
    cyc3(1'b0, 8'h00, 3'b111);
    check("wrap_pops", 32'(pops3), 32'd6);
    check("wrap_sel", 32'(b3.sel), 32'd0);

    // Stall counter saturation
    cyc(1'b1, 8'h55, 2'b00);
    repeat (70000) cyc(1'b0, 8'h00, 2'b00);
    check("sat_stall", 32'(b2.stall_cnt), 32'hFFFF);
    repeat (3) cyc(1'b0, 8'h00, 2'b00);
    check("sat_hold", 32'(b2.stall_cnt), 32'hFFFF);
    cyc(1'b0, 8'h00, 2'b01);
    cyc(1'b0, 8'h00, 2'b00);
    check("sat_drain", 32'(q2.size()), 32'd0);
    check("sat_idle_valid", 32'(b2.out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
